result_drain: RTL
=================

Name: result_drain

Overview:
- Consumer-side counterpart to the accelerator's file_source input feeders.
- Pops evaluated results and their status words, in lockstep, from the result FIFO and status FIFO that the polynomial evaluation accelerator writes.
- Pairs each result with its status, stores the pair in a small log, counts non-zero statuses and flags result/status skew.
- Instantiated at top level beside the FIFOs; the log is read out by the testbench or a host through a read port.

Parameters:
DATA_WIDTH, 32, width of result words
STATUS_WIDTH, 8, width of status words
LOG_DEPTH, 16, number of pair entries in the log
TIMEOUT, 8, cycles of result/status skew tolerated before raising pair_error

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
drain_enable  in  1  permits popping when high
clear_log  in  1  synchronous pulse: empties the log and counters
empty_result  in  1  result FIFO empty
out_result  in  DATA_WIDTH  result FIFO read data (registered read)
r_en_result  out  1  result FIFO read enable
empty_status  in  1  status FIFO empty
out_status  in  STATUS_WIDTH  status FIFO read data (registered read)
r_en_status  out  1  status FIFO read enable
rd_addr  in  $clog2(LOG_DEPTH)  log read index
rd_result  out  DATA_WIDTH  log result at rd_addr
rd_status  out  STATUS_WIDTH  log status at rd_addr
count  out  $clog2(LOG_DEPTH+1)  pairs stored
err_count  out  $clog2(LOG_DEPTH+1)  stored pairs with status != 0
log_full  out  1  count == LOG_DEPTH
pair_error  out  1  sticky skew error

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state IDLE
  - r_en_* = 0, count = 0, err_count = 0, write pointer = 0
  - log_full = 0, pair_error = 0, skew counter = 0
  - log contents need not clear.
- FIFO contract: out_* is valid in the cycle after r_en is sampled high.
- FSM states: IDLE, POP, CAPTURE, FULL, ERROR. Outputs are Moore.
- IDLE:
  - Go to POP when drain_enable & !empty_result & !empty_status & count < LOG_DEPTH.
  - Go to FULL when count == LOG_DEPTH.
- POP:
  - r_en_result = r_en_status = 1 for exactly one cycle; both are always asserted together.
  - Next state is CAPTURE.
- CAPTURE:
  - Write {out_result, out_status} into log[wptr]; wptr++, count++.
  - If out_status != 0, err_count++.
  - Next state is IDLE, or FULL if the new count == LOG_DEPTH.
- Throughput: one pair per 3 cycles. Latency from FIFO non-empty to count increment is 3 edges.
- FULL:
  - log_full = 1; no pops.
  - clear_log → IDLE.
- clear_log:
  - Honoured in IDLE and FULL: count, err_count, wptr ← 0; log_full ← 0.
  - In POP/CAPTURE it is held pending and applied on return to IDLE, after the in-flight pair is written.
  - Ignored in ERROR.
- Skew detection:
  - Evaluated in IDLE only.
  - Exactly one of empty_result/empty_status low → skew counter increments; otherwise it clears.
  - Counter reaching TIMEOUT → ERROR, pair_error = 1.
  - ERROR is exited only by reset; no pops occur in ERROR.
- drain_enable low only blocks IDLE→POP. A pop already in POP/CAPTURE completes.
- Read port: rd_result/rd_status are combinational from log[rd_addr]. They return 0 when rd_addr >= count.
- Reset asserted mid-POP/CAPTURE: the popped pair is discarded and is not logged.
- Simultaneous clear_log and pop condition in IDLE: clear wins, no pop that cycle.

Decomposition:
- Package pea_drain_pkg: drain_state_t enum (IDLE, POP, CAPTURE, FULL, ERROR) and the status-OK constant (0).
- One sub-module, drain_log_ram: LOG_DEPTH × (DATA_WIDTH+STATUS_WIDTH), synchronous write, asynchronous read.

Test Plan:
- Basic pairing: preload results {5, 17, 42} and statuses {0, 0, 3}, drain_enable = 1 → three single-cycle r_en pulses 3 cycles apart; count = 3, err_count = 1; rd_addr = 2 gives rd_result = 42, rd_status = 3.
- Full log: preload 20 pairs with LOG_DEPTH = 16 → count = 16, log_full = 1, exactly 16 pops, FIFOs retain 4 entries; then pulse clear_log → count = 0, the remaining 4 drain, count = 4.
- Skew: push result 9 only, status FIFO empty, TIMEOUT = 8 → pair_error = 1 after 8 IDLE cycles and never pops; a later status push has no effect until reset.
- Enable gating: drain_enable = 0 with both FIFOs non-empty → no r_en for 10 cycles; raising it gives a pop on the next POP cycle.
- Async reset mid-op: drop reset during CAPTURE → all outputs 0 immediately (not at the clock edge); count = 0 after release.
- Clear collision: clear_log pulse in IDLE in the same cycle both FIFOs become non-empty → no pop that cycle, pop begins the next cycle, count ends at 1.

Source files
------------

// File: rtl/pea_drain_pkg.sv
// rtl/pea_drain_pkg.sv - shared types and constants for the result drain
package pea_drain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    CAPTURE = 3'd2,
    FULL    = 3'd3,
    ERROR   = 3'd4
  } drain_state_t;

  localparam int unsigned STATUS_OK = 0;

endpackage

// File: rtl/drain_log_ram.sv
// rtl/drain_log_ram.sv - result/status pair log, synchronous write, asynchronous read
module drain_log_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - pops result/status FIFOs in lockstep and logs the pairs
module result_drain
  import pea_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STATUS_WIDTH = 8,
  parameter int LOG_DEPTH    = 16,
  parameter int TIMEOUT      = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             drain_enable,
  input  logic                             clear_log,
  input  logic                             empty_result,
  input  logic [DATA_WIDTH-1:0]            out_result,
  output logic                             r_en_result,
  input  logic                             empty_status,
  input  logic [STATUS_WIDTH-1:0]          out_status,
  output logic                             r_en_status,
  input  logic [$clog2(LOG_DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_result,
  output logic [STATUS_WIDTH-1:0]          rd_status,
  output logic [$clog2(LOG_DEPTH+1)-1:0]   count,
  output logic [$clog2(LOG_DEPTH+1)-1:0]   err_count,
  output logic                             log_full,
  output logic                             pair_error
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int CW = $clog2(LOG_DEPTH + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int EW = DATA_WIDTH + STATUS_WIDTH;

  drain_state_t    state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   err_q, err_d;
  logic [SW-1:0]   skew_q, skew_d;
  logic            clr_pend_q, clr_pend_d;
  logic            skew_now, do_clear;
  logic [EW-1:0]   ram_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      err_q      <= '0;
      skew_q     <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      skew_q     <= skew_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // A clear arriving mid-transfer is remembered and applied once back in IDLE/FULL.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    err_d      = err_q;
    skew_d     = skew_q;
    clr_pend_d = clr_pend_q;
    skew_now   = empty_result ^ empty_status;
    do_clear   = clear_log | clr_pend_q;
    case (state_q)
      IDLE: begin
        skew_d     = skew_now ? skew_q + 1'b1 : '0;
        clr_pend_d = 1'b0;
        if (skew_now && (skew_q == SW'(TIMEOUT - 1))) begin
          state_d = ERROR;
        end else if (do_clear) begin
          count_d = '0;
          err_d   = '0;
          wptr_d  = '0;
        end else if (count_q == CW'(LOG_DEPTH)) begin
          state_d = FULL;
        end else if (drain_enable && !empty_result && !empty_status) begin
          state_d = POP;
        end
      end
      POP: begin
        if (clear_log) clr_pend_d = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (clear_log) clr_pend_d = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (out_status != STATUS_WIDTH'(STATUS_OK)) err_d = err_q + 1'b1;
        state_d = (count_d == CW'(LOG_DEPTH)) ? FULL : IDLE;
      end
      FULL: begin
        if (do_clear) begin
          count_d    = '0;
          err_d      = '0;
          wptr_d     = '0;
          clr_pend_d = 1'b0;
          state_d    = IDLE;
        end
      end
      ERROR: begin
        clr_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  drain_log_ram #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (EW)
  ) u_log (
    .clock   (clock),
    .we_i    (state_q == CAPTURE),
    .waddr_i (wptr_q),
    .wdata_i ({out_result, out_status}),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign r_en_result = (state_q == POP);
  assign r_en_status = (state_q == POP);
  assign count       = count_q;
  assign err_count   = err_q;
  assign log_full    = (count_q == CW'(LOG_DEPTH));
  assign pair_error  = (state_q == ERROR);
  assign rd_result   = (CW'(rd_addr) < count_q) ? ram_rdata[EW-1:STATUS_WIDTH] : '0;
  assign rd_status   = (CW'(rd_addr) < count_q) ? ram_rdata[STATUS_WIDTH-1:0] : '0;

endmodule
